serial_mag_comparator: RTL and testbench
========================================

Name: serial_mag_comparator

Overview:
- Parametrised, bit-serial magnitude comparator. Successor to the fixed 2-bit combinational comparison function in the CA1 gate-level set.
- Compares two WIDTH-bit operands one bit per clock, MSB first, with early termination at the first differing bit.
- Supports unsigned or two's-complement operands, with a start/done handshake.
- Sits beside the CA1 gate-level comparators and serves as the sequential reference model for them.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a comparison; sampled on the rising edge.
- A  input  WIDTH  operand A; latched when start is accepted.
- B  input  WIDTH  operand B; latched when start is accepted.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when a result becomes valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst is high, the block forces state IDLE, busy=0, done=0, gt=eq=lt=0, index=0 and the operand registers to 0. This applies mid-comparison too: any in-flight operation is aborted and no done pulse is produced.
- State IDLE:
  - busy=0, done=0; gt/eq/lt hold the last result (0 after reset).
  - start=1 at an edge: latch A and B, set index=WIDTH-1, clear gt/eq/lt to 0, go to COMPARE.
- State COMPARE:
  - busy=1. Each cycle examines bit a=Areg[index], b=Breg[index].
  - If a!=b (unsigned, or any bit below the MSB): gt=a, lt=b, go to DONE.
  - If a!=b at index WIDTH-1 and SIGNED=1: the sense is inverted, gt=b, lt=a, go to DONE.
  - If a==b and index==0: eq=1, go to DONE.
  - If a==b and index>0: index decrements by 1; stay in COMPARE.
- State DONE:
  - done=1 and busy=0 for exactly one cycle; gt/eq/lt valid.
  - If start=1 at this edge, it is accepted exactly as from IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: if the start edge is E0 and m bits are examined (m = WIDTH-p, where p is the index of the first differing bit; m = WIDTH when equal), done is high after edge Em. The fastest case is 1 cycle and the slowest is WIDTH cycles.
- start while busy=1 is ignored. The A/B registers are not reloaded and the operation continues undisturbed.
- Exactly one of gt/eq/lt is 1 whenever done=1. All three are 0 from start acceptance until the result.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.
- Input timing: A and B may change freely after the accepting edge.
- index width is $clog2(WIDTH). The decrement never wraps, because the index==0 case exits COMPARE.
- The module is written under `timescale 1ns/1ns, consistent with the rest of CA1.

Test Plan (WIDTH=8):
- Unsigned, MSB differs: SIGNED=0, A=8'hA5, B=8'h3C, start pulse at E0 -> done=1 after E1 with gt=1, eq=0, lt=0; busy high for 1 cycle.
- Signed, MSB differs: SIGNED=1, A=8'hA5 (-91), B=8'h3C (60) -> done after E1 with lt=1 and gt=0.
- Equal operands: A=B=8'h5A -> busy for 8 cycles, done after E8 with eq=1; afterwards the results hold in IDLE until the next start.
- LSB differs, then back-to-back: A=8'h10, B=8'h11 -> done after E8 with lt=1. With start held high in the DONE cycle, loading A=8'h80, B=8'h7F -> the second done arrives 1 cycle later with gt=1.
- Start while busy: start with A=8'h01, B=8'h01, then pulse start again 3 cycles later with A=8'hFF, B=8'h00 -> the second start is ignored; done after E8 with eq=1.
- Reset mid-operation: assert rst asynchronously 4 cycles into an equal compare -> busy, done, gt, eq and lt all go to 0 immediately with no done pulse. After release, a new start with A=8'h02, B=8'h03 gives done after E8 with lt=1.

Source files
------------

// File: rtl/serial_mag_comparator.sv
`timescale 1ns/1ns
// Bit-serial MSB-first magnitude comparator with a start/done handshake.
// Stops at the first differing bit; SIGNED inverts the sense at the sign bit.
module serial_mag_comparator #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;

   logic bit_a;
   logic bit_b;

   assign bit_a = a_q[idx_q];
   assign bit_b = b_q[idx_q];

   // NOTE: the operand registers are reset as well, so an aborted compare leaves no stale data behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   always_comb begin
      // NOTE: every target gets a hold default first, so no path leaves a latch behind.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               idx_d   = MSB_IDX;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = COMPARE;
            end else begin
               state_d = IDLE;
            end
         end

         COMPARE: begin
            if (bit_a != bit_b) begin
               // A 1 in the sign position marks the more negative operand.
               if (SIGNED && (idx_q == MSB_IDX)) begin
                  gt_d = bit_b;
                  lt_d = bit_a;
               end else begin
                  gt_d = bit_a;
                  lt_d = bit_b;
               end
               state_d = DONE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == COMPARE);
      done = (state_q == DONE);
      gt   = gt_q;
      eq   = eq_q;
      lt   = lt_q;
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
`timescale 1ns/1ns
// Bench for serial_mag_comparator: an unsigned and a signed instance share stimulus,
// checked against arithmetic comparison and first-differing-bit latency.
module tb_serial_mag_comparator;

   localparam int W = 8;
   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy_u, done_u, gt_u, eq_u, lt_u;
   logic         busy_s, done_s, gt_s, eq_s, lt_s;
   logic [2:0]   res_u, res_s;

   int n_checks = 0;
   int n_errors = 0;

   assign res_u = {gt_u, eq_u, lt_u};
   assign res_s = {gt_s, eq_s, lt_s};

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy_u), .done(done_u), .gt(gt_u), .eq(eq_u), .lt(lt_u)
   );

   serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy_s), .done(done_s), .gt(gt_s), .eq(eq_s), .lt(lt_s)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   exp_u;
      logic [2:0]   exp_s;
      int           cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic comparison, encoded as {gt, eq, lt}.
   function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      if (sgn) begin
         if ($signed(a) > $signed(b)) return GT;
         if ($signed(a) < $signed(b)) return LT;
         return EQ;
      end
      if (a > b) return GT;
      if (a < b) return LT;
      return EQ;
   endfunction

   // Reference latency: WIDTH minus the position of the highest differing bit.
   function automatic int ref_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
      int x;
      int p;
      x = int'(a ^ b);
      if (x == 0) return W;
      p = 0;
      while (x > 1) begin
         x = x >> 1;
         p++;
      end
      return W - p;
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({name, " busy_u"}, 32'(busy_u), 32'd1);
      check({name, " busy_s"}, 32'(busy_s), 32'd1);
      check({name, " cleared"}, {26'd0, res_u, res_s}, 32'd0);
   endtask

   task automatic finish_op(input logic [2:0] exp_u, input logic [2:0] exp_s,
                            input int exp_cyc, input string name);
      int cyc;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done_u && cyc < W + 3);
      check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
      check({name, " done_s"}, 32'(done_s), 32'd1);
      check({name, " res_u"}, 32'(res_u), 32'(exp_u));
      check({name, " res_s"}, 32'(res_s), 32'(exp_s));
      check({name, " busy_at_done"}, 32'(busy_u | busy_s), 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] exp_u,
                         input logic [2:0] exp_s, input int exp_cyc, input string name);
      start_op(a, b, name);
      finish_op(exp_u, exp_s, exp_cyc, name);
      A = ~a;
      B = ~b;
      @(posedge clk);
      #1;
      check({name, " done_pulse"}, 32'(done_u | done_s), 32'd0);
      check({name, " hold"}, {26'd0, res_u, res_s}, {26'd0, exp_u, exp_s});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         saw_done;

      vecs[0] = '{8'hA5, 8'h3C, GT, LT, 1};
      vecs[1] = '{8'h5A, 8'h5A, EQ, EQ, 8};
      vecs[2] = '{8'h10, 8'h11, LT, LT, 8};
      vecs[3] = '{8'h80, 8'h7F, GT, LT, 1};
      vecs[4] = '{8'h7F, 8'h80, LT, GT, 1};
      vecs[5] = '{8'h00, 8'hFF, LT, GT, 1};
      vecs[6] = '{8'hFF, 8'hFE, GT, GT, 8};
      vecs[7] = '{8'h40, 8'h20, GT, GT, 2};
      vecs[8] = '{8'h00, 8'h00, EQ, EQ, 8};
      vecs[9] = '{8'hC3, 8'hC1, GT, GT, 7};

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", {24'd0, busy_u, done_u, busy_s, done_s, 1'b0, res_u | res_s}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp_u, vecs[i].exp_s, vecs[i].cyc, $sformatf("vec%0d", i));

      // Reset asserted in IDLE clears a held result immediately.
      #2;
      rst = 1'b1;
      #1;
      check("idle reset clears", {26'd0, res_u, res_s}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back: a new start accepted in the DONE cycle.
      start_op(8'h10, 8'h11, "b2b_first");
      finish_op(LT, LT, 8, "b2b_first");
      start_op(8'h80, 8'h7F, "b2b_second");
      finish_op(GT, LT, 1, "b2b_second");
      @(posedge clk);
      #1;
      check("b2b done_pulse", 32'(done_u | done_s), 32'd0);

      // Start while busy must be ignored.
      start_op(8'h01, 8'h01, "busy_start");
      repeat (2) @(posedge clk);
      #1;
      A     = 8'hFF;
      B     = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_op(EQ, EQ, 5, "busy_start");
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a compare aborts it.
      start_op(8'h5A, 8'h5A, "mid_reset");
      repeat (4) @(posedge clk);
      #1;
      check("mid_reset busy_before", 32'(busy_u & busy_s), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_reset async", {24'd0, busy_u, done_u, busy_s, done_s, 1'b0, res_u | res_s}, 32'd0);
      @(posedge clk);
      #1;
      check("mid_reset held", {30'd0, busy_u | busy_s, done_u | done_s}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (W) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done_u | done_s | busy_u | busy_s;
      end
      check("mid_reset no_done", 32'(saw_done), 32'd0);
      run_op(8'h02, 8'h03, LT, LT, 8, "after_reset");

      // Randomised operands, biased towards equal and near-equal pairs.
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         run_op(ra, rb, ref_cmp(ra, rb, 1'b0), ref_cmp(ra, rb, 1'b1), ref_cycles(ra, rb),
                $sformatf("rand%0d a=%0h b=%0h", i, ra, rb));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
